// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status struct and default watermark helper for fifo_flags clients.
package fifo_pkg;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  function automatic int watermark(int aw, bit high);
    return high ? 2 ** aw - 2 : 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DWIDTH storage, one write port, asynchronous read, no reset.
module fifo_ram #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: FWFT FIFO with occupancy count, watermark flags and synchronous flush.
// Define FIFO_FLAGS_ERR_EN to build the sticky overflow/underflow flags.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int AWIDTH     = 4,
  parameter int DWIDTH     = 32,
  parameter int AFULL_LVL  = watermark(AWIDTH, 1'b1),
  parameter int AEMPTY_LVL = watermark(AWIDTH, 1'b0)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              push,
  input  logic [DWIDTH-1:0] in,
  input  logic              pop,
  output logic [DWIDTH-1:0] out,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(2 ** AWIDTH);
  localparam logic [AWIDTH:0] AF      = (AWIDTH+1)'(AFULL_LVL);
  localparam logic [AWIDTH:0] AE      = (AWIDTH+1)'(AEMPTY_LVL);
  logic [AWIDTH-1:0] widx, ridx;
  logic wr_ok, rd_ok, ovf, unf;
  fifo_status_t st;
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  fifo_ram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_ram (
    .clk_i (clk_i),
    .we    (wr_ok && !clear && !rst_i),
    .waddr (widx),
    .wdata (in),
    .raddr (ridx),
    .rdata (out)
  );
  always_ff @(posedge clk_i)
    if (rst_i || clear) begin
      widx  <= '0;
      ridx  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) widx <= widx + AWIDTH'(1);
      if (rd_ok) ridx <= ridx + AWIDTH'(1);
      if (wr_ok != rd_ok) count <= wr_ok ? count + (AWIDTH+1)'(1) : count - (AWIDTH+1)'(1);
    end
`ifdef FIFO_FLAGS_ERR_EN
  always_ff @(posedge clk_i)
    if (rst_i || clear) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      if (pop && empty) unf <= 1'b1;
    end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
  always_comb st = '{
    full:         count == DEPTH_C,
    empty:        count == '0,
    almost_full:  count >= AF,
    almost_empty: count <= AE,
    overflow:     ovf,
    underflow:    unf
  };
  assign {full, empty, almost_full, almost_empty, overflow, underflow} = st;
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed sequence with a queue scoreboard for fifo_flags.
module tb_fifo_flags;
`ifdef FIFO_FLAGS_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, p = 1'b0, q = 1'b0;
  logic [7:0] d = '0, dout;
  logic [2:0] cnt;
  logic full, empty, af, ae, ov, un;
  logic c2 = 1'b0, p2 = 1'b0, q2 = 1'b0;
  logic [7:0] d2 = '0, dout2;
  logic [3:0] cnt2;
  logic full2, empty2, af2, ae2, ov2, un2;
  int checks = 0, errors = 0;
  logic [7:0] sbq[$];
  bit mov = 1'b0, mun = 1'b0;

  always #5 clk = ~clk;

  fifo_flags #(.AWIDTH(2), .DWIDTH(8), .AFULL_LVL(2), .AEMPTY_LVL(1)) dut (
    .clk_i(clk), .rst_i(rst), .clear(clr), .push(p), .in(d), .pop(q), .out(dout),
    .count(cnt), .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .overflow(ov), .underflow(un)
  );

  fifo_flags #(.AWIDTH(3), .DWIDTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear(c2), .push(p2), .in(d2), .pop(q2), .out(dout2),
    .count(cnt2), .full(full2), .empty(empty2), .almost_full(af2), .almost_empty(ae2),
    .overflow(ov2), .underflow(un2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags();
    int n = sbq.size();
    chk("count", 32'(cnt), 32'(n));
    chk("full", 32'(full), 32'(n == 4));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(af), 32'(n >= 2));
    chk("almost_empty", 32'(ae), 32'(n <= 1));
    chk("overflow", 32'(ov), 32'(mov));
    chk("underflow", 32'(un), 32'(mun));
  endtask

  // One clock: drive, check the head before the edge, update the model, check flags after.
  task automatic cyc(input bit ip, input bit iq, input logic [7:0] id, input bit ic, input bit ir);
    int n;
    bit wr, rd;
    p = ip; q = iq; d = id; clr = ic; rst = ir;
    n = sbq.size();
    if (n > 0) chk("out", 32'(dout), 32'(sbq[0]));
    @(posedge clk);
    #1;
    if (ir || ic) begin
      sbq.delete();
      mov = 1'b0;
      mun = 1'b0;
    end else begin
      wr = ip && (n < 4 || iq);
      rd = iq && n > 0;
      if (ERR && ip && n == 4 && !iq) mov = 1'b1;
      if (ERR && iq && n == 0) mun = 1'b1;
      if (rd) void'(sbq.pop_front());
      if (wr) sbq.push_back(id);
    end
    p = 1'b0; q = 1'b0; clr = 1'b0; rst = 1'b0;
    flags();
  endtask

  task automatic fill_over();
    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i * 16 + i), 0, 0);
    cyc(1, 0, 8'h55, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    chk("reset_empty2", 32'(empty2), 32'd1);
    fill_over();
    chk("ovf_after_fifth", 32'(ov), 32'(ERR));
    repeat (4) cyc(0, 1, 0, 0, 0);
    chk("drained_empty", 32'(empty), 32'd1);
    cyc(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i * 16 + i), 0, 0);
    cyc(1, 1, 8'hAA, 0, 0);
    chk("full_pushpop_ovf", 32'(ov), 32'd0);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 8'h5A, 0, 0);
    chk("empty_pushpop_unf", 32'(un), 32'(ERR));
    for (int i = 0; i < 12; i++) cyc(1, 1, 8'(8'hC0 + i), 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    fill_over();
    cyc(1, 0, 8'h66, 1, 0);
    chk("clear_count", 32'(cnt), 32'd0);
    fill_over();
    cyc(1, 1, 8'h77, 0, 1);
    chk("rst_count", 32'(cnt), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      p2 = 1'b1;
      d2 = 8'(k);
      @(posedge clk);
      #1;
      p2 = 1'b0;
      chk("wm_count", 32'(cnt2), 32'(k));
      chk("wm_almost_empty", 32'(ae2), 32'(k <= 2));
      chk("wm_almost_full", 32'(af2), 32'(k >= 6));
      chk("wm_full", 32'(full2), 32'(k == 8));
    end
    chk("wm_head", 32'(dout2), 32'd1);
    chk("wm_ovf", 32'(ov2 | un2 | empty2), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
